iop_queue: RTL and testbench

Micro-op scheduling queue between the front end's decode stage and the execute stage. Each accepted decode output (micro-op word, init step, 16-bit argument) is written into a small circular FIFO. The execute stage pops entries from the head in order. The queue reports a free-slot indication back to the front end, tracks queued flag-writing micro-ops for flag-hazard checks, and is cleared in one cycle when execute redirects the PC.

---
 rtl/iop_queue.sv | 98 +++++++++
 tb/tb_iop_queue.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/iop_queue.sv
// Micro-op scheduling queue between decode and execute: a circular FIFO of
// {iop, init, arg} entries with flag-writer tracking, flush and overflow flag.
module iop_queue #(
    parameter int DEPTH = 4,
    parameter int IOP_W = 32
) (
    input  logic             clk,
    input  logic             a_rst,
    input  logic             id_feed_req,
    input  logic [IOP_W-1:0] id_iop,
    input  logic [2:0]       id_iop_init,
    input  logic [15:0]      id_arg,
    output logic             ex_feed_slot,
    input  logic             q_flush,
    input  logic             ex_take,
    output logic             ex_valid,
    output logic [IOP_W-1:0] ex_iop,
    output logic [2:0]       ex_iop_init,
    output logic [15:0]      ex_arg,
    output logic             q_sf_busy,
    output logic             q_ovf
);

    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW     = AW + 1;
    localparam int EW     = IOP_W + 19;
    localparam int SF_BIT = 21;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;
    logic [CW-1:0] sf_cnt;
    logic [EW-1:0] head_ent;
    logic          push;
    logic          pop;
    logic          push_sf;
    logic          pop_sf;

    assign ex_feed_slot = (count != FULL_CNT);
    assign ex_valid     = (count != '0);
    assign push         = id_feed_req & ex_feed_slot & ~q_flush;
    assign pop          = ex_take & ex_valid & ~q_flush;

    // Entry layout: {iop, init, arg}; the flag-writer bit sits 19 above iop bit 0.
    assign head_ent = mem[head];
    assign push_sf  = push & id_iop[SF_BIT];
    assign pop_sf   = pop & head_ent[19 + SF_BIT];

    assign {ex_iop, ex_iop_init, ex_arg} = ex_valid ? head_ent : '0;
    assign q_sf_busy = (sf_cnt != '0);

    // Storage is never cleared; stale slots are masked by count.
    always_ff @(posedge clk) begin
        if (a_rst && push) begin
            mem[tail] <= {id_iop, id_iop_init, id_arg};
        end
    end

    always_ff @(posedge clk) begin
        if (!a_rst) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            sf_cnt <= '0;
            q_ovf  <= 1'b0;
        end else begin
            if (id_feed_req && !ex_feed_slot && !q_flush) begin
                q_ovf <= 1'b1;
            end
            if (q_flush) begin
                head   <= '0;
                tail   <= '0;
                count  <= '0;
                sf_cnt <= '0;
            end else begin
                if (push) begin
                    tail <= tail + 1'b1;
                end
                if (pop) begin
                    head <= head + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
                case ({push_sf, pop_sf})
                    2'b10:   sf_cnt <= sf_cnt + 1'b1;
                    2'b01:   sf_cnt <= sf_cnt - 1'b1;
                    default: sf_cnt <= sf_cnt;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_iop_queue.sv
// Scoreboard bench for iop_queue: accepted pushes are queued as expected
// entries and compared against the head whenever the queue model is non-empty.
module tb_iop_queue;

    localparam int DEPTH = 4;
    localparam int IOP_W = 32;

    logic             clk = 1'b0;
    logic             a_rst;
    logic             id_feed_req;
    logic [IOP_W-1:0] id_iop;
    logic [2:0]       id_iop_init;
    logic [15:0]      id_arg;
    logic             ex_feed_slot;
    logic             q_flush;
    logic             ex_take;
    logic             ex_valid;
    logic [IOP_W-1:0] ex_iop;
    logic [2:0]       ex_iop_init;
    logic [15:0]      ex_arg;
    logic             q_sf_busy;
    logic             q_ovf;

    typedef struct {
        logic [31:0] iop;
        logic [2:0]  init;
        logic [15:0] arg;
    } ent_t;

    ent_t sb[$];
    bit   ovf_exp = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    iop_queue #(.DEPTH(DEPTH), .IOP_W(IOP_W)) dut (
        .clk          (clk),
        .a_rst        (a_rst),
        .id_feed_req  (id_feed_req),
        .id_iop       (id_iop),
        .id_iop_init  (id_iop_init),
        .id_arg       (id_arg),
        .ex_feed_slot (ex_feed_slot),
        .q_flush      (q_flush),
        .ex_take      (ex_take),
        .ex_valid     (ex_valid),
        .ex_iop       (ex_iop),
        .ex_iop_init  (ex_iop_init),
        .ex_arg       (ex_arg),
        .q_sf_busy    (q_sf_busy),
        .q_ovf        (q_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit sf_exp();
        foreach (sb[i]) begin
            if (sb[i].iop[21]) return 1'b1;
        end
        return 1'b0;
    endfunction

    // One cycle: check outputs at the falling edge, drive inputs, update model.
    task automatic step(input bit req, input logic [31:0] iop, input logic [2:0] init,
                        input logic [15:0] arg, input bit take, input bit flush,
                        input bit rst_n);
        bit   full;
        bit   do_push;
        bit   do_pop;
        ent_t e;
        @(negedge clk);
        check("ex_valid", 64'(ex_valid), 64'(sb.size() != 0));
        check("ex_feed_slot", 64'(ex_feed_slot), 64'(sb.size() != DEPTH));
        check("q_sf_busy", 64'(q_sf_busy), 64'(sf_exp()));
        check("q_ovf", 64'(q_ovf), 64'(ovf_exp));
        if (sb.size() != 0) begin
            check("head_iop", 64'(ex_iop), 64'(sb[0].iop));
            check("head_init", 64'(ex_iop_init), 64'(sb[0].init));
            check("head_arg", 64'(ex_arg), 64'(sb[0].arg));
        end else begin
            check("empty_iop", 64'(ex_iop), 64'h0);
            check("empty_arg", 64'({ex_iop_init, ex_arg}), 64'h0);
        end
        id_feed_req = req;
        id_iop      = iop;
        id_iop_init = init;
        id_arg      = arg;
        ex_take     = take;
        q_flush     = flush;
        a_rst       = rst_n;
        if (!rst_n) begin
            sb.delete();
            ovf_exp = 1'b0;
        end else if (flush) begin
            sb.delete();
        end else begin
            full    = (sb.size() == DEPTH);
            do_push = req && !full;
            do_pop  = take && (sb.size() != 0);
            if (req && full) ovf_exp = 1'b1;
            if (do_pop) void'(sb.pop_front());
            if (do_push) begin
                e.iop  = iop;
                e.init = init;
                e.arg  = arg;
                sb.push_back(e);
            end
        end
        @(posedge clk);
    endtask

    task automatic idle();
        step(0, 32'h0, 3'h0, 16'h0, 0, 0, 1);
    endtask

    task automatic push(input logic [31:0] iop, input logic [2:0] init, input logic [15:0] arg);
        step(1, iop, init, arg, 0, 0, 1);
    endtask

    task automatic pop();
        step(0, 32'h0, 3'h0, 16'h0, 1, 0, 1);
    endtask

    initial begin
        a_rst       = 1'b0;
        id_feed_req = 1'b0;
        id_iop      = '0;
        id_iop_init = '0;
        id_arg      = '0;
        ex_take     = 1'b0;
        q_flush     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        a_rst = 1'b1;

        // reset state, then single push / pop
        idle();
        push(32'h0000_1234, 3'd3, 16'hBEEF);
        pop();
        idle();

        // fill, overflow attempt, drain in order
        for (int i = 1; i <= 4; i++) push(32'(i), 3'(i), 16'(i * 16'h111));
        push(32'h5, 3'd5, 16'h5555);
        for (int i = 0; i < 4; i++) pop();
        idle();

        // steady push+pop with three in flight, pointers wrap
        for (int i = 0; i < 3; i++) push(32'hA0 + 32'(i), 3'(i), 16'hA000 + 16'(i));
        for (int i = 0; i < 10; i++) step(1, 32'h10 + 32'(i), 3'(i), 16'(i), 1, 0, 1);
        for (int i = 0; i < 3; i++) pop();
        idle();

        // flag-writer tracking
        push(32'h0020_0001, 3'd1, 16'h1);
        push(32'h0000_0002, 3'd2, 16'h2);
        push(32'h0020_0003, 3'd3, 16'h3);
        pop();
        pop();
        pop();
        idle();

        // flush with concurrent push+pop, then refill
        for (int i = 0; i < 3; i++) push(32'h0020_0030 + 32'(i), 3'(i), 16'h30 + 16'(i));
        step(1, 32'h0020_00FF, 3'd7, 16'hFFFF, 1, 1, 1);
        push(32'h0000_0077, 3'd6, 16'h7777);
        idle();
        pop();

        // reset mid-stream clears entries and the sticky overflow
        for (int i = 0; i < 5; i++) push(32'h0020_0040 + 32'(i), 3'(i), 16'h40 + 16'(i));
        step(0, 32'h0, 3'h0, 16'h0, 0, 0, 0);
        idle();
        push(32'h0000_0099, 3'd1, 16'h9999);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            step(bit'($urandom_range(0, 3) != 0), $urandom() | (32'($urandom_range(0, 1)) << 21),
                 3'($urandom()), 16'($urandom()), bit'($urandom_range(0, 2) != 0),
                 bit'($urandom_range(0, 40) == 0), 1);
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
